stepgen_nch: RTL and testbench
==============================

STEPGEN_NCH -- requirements
Module: stepgen_nch

Interface
REQ-001 Parameter NUM_CH, default 5: number of step/dir channels, legal range 1..8.
REQ-002 Parameter PULSE_CYCLES, default 64: stp high time, and also the minimum low time, in clk cycles; must be >= 1.
REQ-003 Parameter DIR_SETUP_CYCLES, default 32: cycles from a dir change to the following stp rise; must be >= 1.
REQ-004 clk  in  1: the single system clock; all logic is on its rising edge.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 freq_cmd  in  32*NUM_CH: signed frequency word per channel; channel k occupies bits [32k+31:32k].
REQ-007 enable  in  NUM_CH: per-channel joint enable.
REQ-008 error  in  1: global fault (estop or interface timeout); suppresses new steps on all channels.
REQ-009 overrun_clr  in  1: single-cycle pulse that clears all overrun flags.
REQ-010 stp  out  NUM_CH: step pulses.
REQ-011 dir  out  NUM_CH: direction; 1 = negative freq_cmd.
REQ-012 feedback  out  32*NUM_CH: signed step position per channel, packed the same way as freq_cmd.
REQ-013 overrun  out  NUM_CH: sticky flag meaning a step request was lost.
REQ-014 ena  out  1: registered value of (|enable) & ~error.

Function
REQ-015 Each channel shall have a 32-bit unsigned phase accumulator acc, a running flag run = enable[k] & ~error, and a magnitude mag = |freq_cmd|. The value -2^31 gives mag 2^31.
REQ-016 While run is 1, acc shall load acc+mag each cycle. A carry out of bit 31 is a step request that samples req_dir = freq_cmd[31].
REQ-017 While run is 0, acc shall load 0 and no step requests shall occur.
REQ-018 A step request shall set that channel's pending bit and latch pend_dir at the same edge.
REQ-019 A step request while pending is already 1 and not being consumed that cycle shall set overrun[k]. pending stays 1 and pend_dir takes the newer value.
REQ-020 If a request and a consumption happen in the same cycle, pending shall stay 1 with the new pend_dir, and overrun shall not set.
REQ-021 Each channel shall run an FSM with states IDLE, SETUP, HIGH and LOW, plus a cycle counter.
REQ-022 IDLE with pending and pend_dir == dir: go to HIGH and consume pending.
REQ-023 IDLE with pending and pend_dir != dir: go to SETUP, load dir from pend_dir at the same edge, and consume pending.
REQ-024 SETUP: go to HIGH after DIR_SETUP_CYCLES cycles.
REQ-025 HIGH: go to LOW after PULSE_CYCLES cycles.
REQ-026 LOW: go to IDLE after PULSE_CYCLES cycles.
REQ-027 stp[k] shall be a registered output equal to 1 exactly while the state is HIGH.
REQ-028 dir shall change only on the IDLE-to-SETUP transition. It never changes while stp is high or within DIR_SETUP_CYCLES of a stp rise.
REQ-029 feedback[k] shall add 1 (dir=0) or subtract 1 (dir=1) on each entry to HIGH, wrapping modulo 2^32.
REQ-030 Latency with no dir change: stp rises 2 clk edges after the edge at which acc wraps.
REQ-031 Latency with a dir change: stp rises 2+DIR_SETUP_CYCLES edges after the wrap edge.
REQ-032 When run drops, a SETUP, HIGH or LOW already in progress shall complete with full timing. Pending shall be cleared, so no truncated or extra pulses occur.
REQ-033 freq_cmd = 0 shall produce no steps, and acc shall hold its value.
REQ-034 overrun_clr shall clear all overrun bits. A set event in the same cycle wins over the clear.
REQ-035 Channels shall be fully independent except for the shared error, overrun_clr and ena.

Reset
REQ-036 On rst, at the next edge: acc=0, pending=0, state=IDLE, counter=0, stp=0, dir=0, feedback=0, overrun=0, ena=0.
REQ-037 rst shall take effect mid-pulse, truncating any stp pulse in progress.
REQ-038 Outputs shall hold their reset values while rst is high.

Structure
REQ-039 Package stepgen_pkg shall hold the FSM state encoding, the default PULSE_CYCLES and DIR_SETUP_CYCLES, and FREQ_W=32.
REQ-040 A per-channel sub-module stepgen_channel shall hold acc, pending, the FSM, the counter and feedback.
REQ-041 stepgen_nch shall instantiate NUM_CH copies of stepgen_channel via generate and contain the ena register.
REQ-042 Counter width shall be clog2(max(PULSE_CYCLES, DIR_SETUP_CYCLES)+1).

Verification (NUM_CH=3, PULSE_CYCLES=4, DIR_SETUP_CYCLES=3)
REQ-043 Reset then freq_cmd0=2^28, enable=001 -> stp0 period 16 cycles, high 4; dir0=0; feedback0=10 after 10 pulses; overrun0=0.
REQ-044 Running freq_cmd1=+2^28, then switch to -2^28 -> dir1 rises 3 cycles before the next stp1 rise, never while stp1=1; feedback1 decrements from that pulse on.
REQ-045 freq_cmd2=2^31 (request every 2 cycles, service takes 8) -> overrun2=1 within 8 cycles; overrun_clr pulse while still running -> overrun2 reasserts; set wins over clear in the same cycle.
REQ-046 error=1 one cycle after a stp0 rise -> that pulse stays high 4 cycles, no further pulses, ena=0 next cycle, feedback0 held; error=0 -> stepping resumes from acc=0.
REQ-047 feedback preloaded via 2^32-1 steps, or forced to 32'hFFFFFFFF, then one +step -> 0; a -step from 0 -> 32'hFFFFFFFF.
REQ-048 rst=1 during HIGH -> stp, dir, feedback and overrun are 0 after the next edge; freq_cmd=-2^31 is accepted as mag 2^31 with dir=1.

Source files
------------

// File: rtl/stepgen_pkg.sv
// Shared types and defaults for the multi-channel step/dir pulse generator.
package stepgen_pkg;

    localparam int FREQ_W               = 32;
    localparam int PULSE_CYCLES_DEF     = 64;
    localparam int DIR_SETUP_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } step_state_t;

    // Unsigned magnitude of a two's-complement word; the most negative value maps to 2^(W-1).
    function automatic logic [FREQ_W-1:0] freq_mag(input logic [FREQ_W-1:0] f);
        return f[FREQ_W-1] ? (~f + 1'b1) : f;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stepgen_channel.sv
// One step/dir channel: phase accumulator, pending-request latch, pulse FSM and position counter.
module stepgen_channel
    import stepgen_pkg::*;
#(
    parameter int PULSE_CYCLES     = PULSE_CYCLES_DEF,
    parameter int DIR_SETUP_CYCLES = DIR_SETUP_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [FREQ_W-1:0] freq_cmd,
    input  logic              run,
    input  logic              overrun_clr,
    output logic              stp,
    output logic              dir,
    output logic [FREQ_W-1:0] feedback,
    output logic              overrun
);

    localparam int CNT_W = $clog2(max_int(PULSE_CYCLES, DIR_SETUP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP_CYCLES - 1);

    step_state_t       state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [FREQ_W-1:0] acc_reg, acc_next;
    logic              carry_reg, carry_next;
    logic              carry_dir_reg, carry_dir_next;
    logic              pending_reg, pending_next;
    logic              pend_dir_reg, pend_dir_next;
    logic              dir_reg, dir_next;
    logic              stp_reg;
    logic [FREQ_W-1:0] feedback_reg, feedback_next;
    logic              overrun_reg, overrun_next;

    logic [FREQ_W:0]   sum;
    logic [FREQ_W-1:0] feedback_step;
    logic              req;
    logic              consume;

    assign sum           = {1'b0, acc_reg} + {1'b0, freq_mag(freq_cmd)};
    assign feedback_step = dir_reg ? (feedback_reg - 1'b1) : (feedback_reg + 1'b1);
    // The carry is registered alongside acc, so a request is seen one edge after the wrap.
    assign req           = carry_reg & run;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        dir_next      = dir_reg;
        feedback_next = feedback_reg;
        consume       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Requests left over when run drops are discarded, never started.
                if (pending_reg && run) begin
                    consume  = 1'b1;
                    cnt_next = '0;
                    if (pend_dir_reg == dir_reg) begin
                        state_next    = ST_HIGH;
                        feedback_next = feedback_step;
                    end else begin
                        state_next = ST_SETUP;
                        dir_next   = pend_dir_reg;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_reg == SETUP_LAST) begin
                    state_next    = ST_HIGH;
                    cnt_next      = '0;
                    feedback_next = feedback_step;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_reg == PULSE_LAST) begin
                    state_next = ST_LOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_LOW: begin
                if (cnt_reg == PULSE_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        pending_next   = pending_reg;
        pend_dir_next  = pend_dir_reg;
        overrun_next   = overrun_reg;
        acc_next       = '0;
        carry_next     = 1'b0;
        carry_dir_next = carry_dir_reg;
        if (!run) begin
            pending_next = 1'b0;
        end else if (req) begin
            pending_next  = 1'b1;
            pend_dir_next = carry_dir_reg;
        end else if (consume) begin
            pending_next = 1'b0;
        end
        if (req && pending_reg && !consume) begin
            overrun_next = 1'b1;
        end else if (overrun_clr) begin
            overrun_next = 1'b0;
        end
        if (run) begin
            acc_next       = sum[FREQ_W-1:0];
            carry_next     = sum[FREQ_W];
            carry_dir_next = freq_cmd[FREQ_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            carry_reg     <= 1'b0;
            carry_dir_reg <= 1'b0;
            pending_reg   <= 1'b0;
            pend_dir_reg  <= 1'b0;
            dir_reg       <= 1'b0;
            stp_reg       <= 1'b0;
            feedback_reg  <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            carry_reg     <= carry_next;
            carry_dir_reg <= carry_dir_next;
            pending_reg   <= pending_next;
            pend_dir_reg  <= pend_dir_next;
            dir_reg       <= dir_next;
            stp_reg       <= (state_next == ST_HIGH);
            feedback_reg  <= feedback_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign stp      = stp_reg;
    assign dir      = dir_reg;
    assign feedback = feedback_reg;
    assign overrun  = overrun_reg;

endmodule

// File: rtl/stepgen_nch.sv
// Multi-channel step/dir generator: NUM_CH independent channels sharing fault, overrun clear and ena.
module stepgen_nch
    import stepgen_pkg::*;
#(
    parameter int NUM_CH           = 5,
    parameter int PULSE_CYCLES     = PULSE_CYCLES_DEF,
    parameter int DIR_SETUP_CYCLES = DIR_SETUP_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FREQ_W*NUM_CH-1:0] freq_cmd,
    input  logic [NUM_CH-1:0]        enable,
    input  logic                     error,
    input  logic                     overrun_clr,
    output logic [NUM_CH-1:0]        stp,
    output logic [NUM_CH-1:0]        dir,
    output logic [FREQ_W*NUM_CH-1:0] feedback,
    output logic [NUM_CH-1:0]        overrun,
    output logic                     ena
);

    logic ena_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ena_reg <= 1'b0;
        end else begin
            ena_reg <= (|enable) & ~error;
        end
    end

    assign ena = ena_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            logic run;
            assign run = enable[gi] & ~error;

            stepgen_channel #(
                .PULSE_CYCLES    (PULSE_CYCLES),
                .DIR_SETUP_CYCLES(DIR_SETUP_CYCLES)
            ) u_ch (
                .clk        (clk),
                .srst       (rst),
                .freq_cmd   (freq_cmd[gi*FREQ_W +: FREQ_W]),
                .run        (run),
                .overrun_clr(overrun_clr),
                .stp        (stp[gi]),
                .dir        (dir[gi]),
                .feedback   (feedback[gi*FREQ_W +: FREQ_W]),
                .overrun    (overrun[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_stepgen_nch.sv
// Bench for stepgen_nch: timestamp-based reference model, vector table, corner sequences, random run.
module tb_stepgen_nch;

    localparam int NCH = 3;
    localparam int P   = 4;
    localparam int D   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [32*NCH-1:0] freq_cmd;
    logic [NCH-1:0]    enable;
    logic              error;
    logic              overrun_clr;
    logic [NCH-1:0]    stp;
    logic [NCH-1:0]    dir;
    logic [32*NCH-1:0] feedback;
    logic [NCH-1:0]    overrun;
    logic              ena;

    always #5 clk = ~clk;

    stepgen_nch #(.NUM_CH(NCH), .PULSE_CYCLES(P), .DIR_SETUP_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .freq_cmd(freq_cmd), .enable(enable), .error(error),
        .overrun_clr(overrun_clr), .stp(stp), .dir(dir), .feedback(feedback),
        .overrun(overrun), .ena(ena)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: pulses are tracked as rise timestamps and a "free again" edge index.
    longint    m_acc  [NCH];
    bit        m_creq [NCH];
    bit        m_cdir [NCH];
    bit        m_pend [NCH];
    bit        m_pdir [NCH];
    bit        m_dir  [NCH];
    bit        m_ovr  [NCH];
    int        m_rise [NCH];
    int        m_free [NCH];
    bit [31:0] m_fb   [NCH];
    bit        m_ena;

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_acc[k] = 0; m_creq[k] = 0; m_cdir[k] = 0; m_pend[k] = 0; m_pdir[k] = 0;
            m_dir[k] = 0; m_ovr[k] = 0; m_rise[k] = -1000; m_free[k] = 0; m_fb[k] = 0;
        end
        m_ena = 0;
    endfunction

    function automatic void model_edge();
        int     fi;
        longint mag;
        longint s;
        bit     run;
        bit     reqn;
        bit     consume;
        bit     set_ev;
        cyc++;
        if (rst) begin
            model_reset();
            return;
        end
        m_ena = (|enable) && !error;
        for (int k = 0; k < NCH; k++) begin
            fi      = $signed(freq_cmd[k*32 +: 32]);
            mag     = fi;
            if (mag < 0) mag = -mag;
            run     = enable[k] && !error;
            reqn    = m_creq[k] && run;
            consume = (cyc >= m_free[k]) && m_pend[k] && run;
            if (consume) begin
                if (m_pdir[k] == m_dir[k]) begin
                    m_rise[k] = cyc;
                end else begin
                    m_dir[k]  = m_pdir[k];
                    m_rise[k] = cyc + D;
                end
                m_free[k] = m_rise[k] + 2*P + 1;
            end
            if (cyc == m_rise[k]) m_fb[k] = m_dir[k] ? m_fb[k] - 1 : m_fb[k] + 1;
            set_ev = reqn && m_pend[k] && !consume;
            if (!run) m_pend[k] = 0;
            else if (reqn) begin m_pend[k] = 1; m_pdir[k] = m_cdir[k]; end
            else if (consume) m_pend[k] = 0;
            if (set_ev) m_ovr[k] = 1;
            else if (overrun_clr) m_ovr[k] = 0;
            if (run) begin
                s         = m_acc[k] + mag;
                m_creq[k] = (s >= (longint'(1) << 32));
                m_acc[k]  = s % (longint'(1) << 32);
                m_cdir[k] = (fi < 0);
            end else begin
                m_acc[k]  = 0;
                m_creq[k] = 0;
            end
        end
    endfunction

    function automatic bit exp_stp(input int k);
        return (cyc >= m_rise[k]) && (cyc < m_rise[k] + P);
    endfunction

    task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d cyc=%0d got=%h want=%h", name, ch, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < NCH; k++) begin
            chk("model_stp", k, stp[k], exp_stp(k));
            chk("model_dir", k, dir[k], m_dir[k]);
            chk("model_ovr", k, overrun[k], m_ovr[k]);
            chk("model_fb", k, feedback[k*32 +: 32], m_fb[k]);
        end
        chk("model_ena", 0, ena, m_ena);
    endtask

    task automatic do_reset();
        rst = 1; freq_cmd = '0; enable = '0; error = 0; overrun_clr = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic wait_rise(input int ch, input int bound, output int n);
        logic prev;
        prev = stp[ch];
        for (n = 1; n <= bound; n++) begin
            tick();
            if (stp[ch] && !prev) return;
            prev = stp[ch];
        end
        checks++; errors++;
        $display("FAIL wait_rise ch%0d: no stp rise within %0d cycles", ch, bound);
        n = -1;
    endtask

    function automatic logic [31:0] pick_freq();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'h1000_0000;
            2: v = 32'hF000_0000;
            3: v = 32'h8000_0000;
            4: v = $urandom;
            default: begin
                v = $urandom_range(1, 32'h0800_0000);
                if ($urandom_range(0, 1) == 1) v = -v;
            end
        endcase
        return v;
    endfunction

    typedef struct {
        logic [2:0][31:0] f;
        logic [2:0]       en;
        logic             err;
        logic [2:0][31:0] fb;
        logic [2:0]       stp_e;
        logic [2:0]       dir_e;
        logic [2:0]       ovr_e;
        logic             ena_e;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n, hi, dir_cyc, rise_cyc, sel;
        logic prev_dir, prev_stp, seen;
        logic [31:0] fb_before;

        tbl[0] = '{f: {32'h0800_0000, 32'hF000_0000, 32'h1000_0000}, en: 3'b111, err: 1'b0,
                   fb: {32'd5, 32'hFFFF_FFF6, 32'd10}, stp_e: 3'b000, dir_e: 3'b010, ovr_e: 3'b000, ena_e: 1'b1};
        tbl[1] = '{f: {32'h0, 32'h7FFF_FFFF, 32'h8000_0000}, en: 3'b011, err: 1'b0,
                   fb: {32'd0, 32'd19, 32'hFFFF_FFED}, stp_e: 3'b011, dir_e: 3'b001, ovr_e: 3'b011, ena_e: 1'b1};
        tbl[2] = '{f: {32'h1000_0000, 32'h1000_0000, 32'h1000_0000}, en: 3'b000, err: 1'b0,
                   fb: '0, stp_e: 3'b000, dir_e: 3'b000, ovr_e: 3'b000, ena_e: 1'b0};
        tbl[3] = '{f: {32'h1000_0000, 32'h1000_0000, 32'h1000_0000}, en: 3'b111, err: 1'b1,
                   fb: '0, stp_e: 3'b000, dir_e: 3'b000, ovr_e: 3'b000, ena_e: 1'b0};
        tbl[4] = '{f: '0, en: 3'b111, err: 1'b0,
                   fb: '0, stp_e: 3'b000, dir_e: 3'b000, ovr_e: 3'b000, ena_e: 1'b1};

        model_reset();
        rst = 1; freq_cmd = '0; enable = '0; error = 0; overrun_clr = 0;
        tick(); tick(); tick();
        chk("reset_stp", 0, stp, 0);
        chk("reset_dir", 0, dir, 0);
        chk("reset_ovr", 0, overrun, 0);
        chk("reset_fb_or", 0, |feedback, 0);
        chk("reset_ena", 0, ena, 0);
        $display("reset: stp=%b dir=%b ovr=%b ena=%b", stp, dir, overrun, ena);

        for (int r = 0; r < 5; r++) begin
            do_reset();
            freq_cmd = tbl[r].f; enable = tbl[r].en; error = tbl[r].err;
            repeat (170) tick();
            for (int k = 0; k < NCH; k++) chk("row_fb", k, feedback[k*32 +: 32], tbl[r].fb[k]);
            chk("row_stp", r, stp, tbl[r].stp_e);
            chk("row_dir", r, dir, tbl[r].dir_e);
            chk("row_ovr", r, overrun, tbl[r].ovr_e);
            chk("row_ena", r, ena, tbl[r].ena_e);
            $display("row %0d: fb0=%h fb1=%h fb2=%h stp=%b dir=%b ovr=%b ena=%b", r,
                     feedback[31:0], feedback[63:32], feedback[95:64], stp, dir, overrun, ena);
        end

        // Direction reversal: setup gap before the next rise, then position counts down.
        do_reset();
        freq_cmd[63:32] = 32'h1000_0000; enable = 3'b010;
        wait_rise(1, 40, n); wait_rise(1, 40, n);
        fb_before = feedback[63:32];
        freq_cmd[63:32] = 32'hF000_0000;
        prev_dir = dir[1]; prev_stp = stp[1]; dir_cyc = -100; rise_cyc = -1;
        for (int i = 0; i < 60 && rise_cyc < 0; i++) begin
            tick();
            if (dir[1] && !prev_dir) begin
                dir_cyc = cyc;
                chk("dir_while_stp", 1, stp[1], 0);
            end
            if (stp[1] && !prev_stp && dir_cyc >= 0) rise_cyc = cyc;
            prev_dir = dir[1]; prev_stp = stp[1];
        end
        chk("dir_setup_gap", 1, rise_cyc - dir_cyc, D);
        chk("fb_dec", 1, feedback[63:32], fb_before - 1);
        $display("dir reversal: dir edge %0d, stp edge %0d", dir_cyc, rise_cyc);

        // Overrun: sets fast at max rate, clears on the pulse, reasserts, set beats clear.
        do_reset();
        freq_cmd[95:64] = 32'h8000_0000; enable = 3'b100;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin tick(); seen = overrun[2]; end
        chk("ovr_within_8", 2, seen, 1);
        overrun_clr = 1; tick(); overrun_clr = 0;
        chk("ovr_cleared", 2, overrun[2], 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = overrun[2]; end
        chk("ovr_reassert", 2, seen, 1);
        overrun_clr = 1; seen = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (overrun[2]) seen = 1; end
        overrun_clr = 0;
        chk("set_beats_clr", 2, seen, 1);
        $display("overrun sequence: ovr=%b", overrun);

        // Fault one cycle into a pulse: pulse completes, nothing new, then restart from acc=0.
        do_reset();
        freq_cmd[31:0] = 32'h1000_0000; enable = 3'b001;
        wait_rise(0, 40, n);
        hi = 1; error = 1;
        tick();
        chk("ena_after_error", 0, ena, 0);
        if (stp[0]) hi++;
        for (int i = 0; i < 40; i++) begin tick(); if (stp[0]) hi++; end
        chk("pulse_len_on_error", 0, hi, P);
        chk("fb_held", 0, feedback[31:0], 1);
        error = 0;
        wait_rise(0, 40, n);
        chk("resume_latency", 0, n, 18);
        $display("error sequence: high=%0d resume=%0d", hi, n);

        // Feedback wrap in both directions.
        do_reset();
        freq_cmd[31:0] = 32'hF000_0000; enable = 3'b001;
        wait_rise(0, 40, n);
        chk("fb_minus_wrap", 0, feedback[31:0], 32'hFFFF_FFFF);
        freq_cmd[31:0] = 32'h1000_0000;
        wait_rise(0, 60, n);
        chk("fb_plus_wrap", 0, feedback[31:0], 32'h0);
        $display("wrap sequence: fb0=%h", feedback[31:0]);

        // Most negative command, then reset in the middle of a pulse.
        do_reset();
        freq_cmd[31:0] = 32'h8000_0000; enable = 3'b001;
        wait_rise(0, 40, n);
        chk("dir_neg_min", 0, dir[0], 1);
        chk("fb_neg_min", 0, feedback[31:0], 32'hFFFF_FFFF);
        wait_rise(0, 40, n);
        tick();
        chk("stp_before_rst", 0, stp[0], 1);
        chk("ovr_before_rst", 0, overrun[0], 1);
        rst = 1;
        tick();
        chk("rst_stp", 0, stp[0], 0);
        chk("rst_dir", 0, dir[0], 0);
        chk("rst_fb", 0, feedback[31:0], 0);
        chk("rst_ovr", 0, overrun[0], 0);
        repeat (3) tick();
        chk("rst_hold_stp", 0, stp, 0);
        chk("rst_hold_ena", 0, ena, 0);
        rst = 0;
        $display("mid-pulse reset: stp=%b dir=%b ovr=%b", stp, dir, overrun);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < NCH; k++)
                if ($urandom_range(0, 15) == 0) freq_cmd[k*32 +: 32] = pick_freq();
            if ($urandom_range(0, 63) == 0) begin
                sel = $urandom_range(0, NCH - 1);
                enable[sel] = ~enable[sel];
            end
            if ($urandom_range(0, 199) == 0) error = ~error;
            overrun_clr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        $display("random phase: %0d cycles", 2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
